updown_mod_counter: RTL and testbench

Parametrised synchronous up/down counter with programmable modulo limit, parallel load, a prescaler, wrap or saturate mode, a terminal-count pulse and a sticky overflow flag. It replaces the fixed 8-bit loadable up-counter in the design. It is used wherever the design needs a configurable event counter or timebase.

---
 rtl/updown_mod_counter.sv | 83 ++++++++
 tb/tb_updown_mod_counter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with load, prescaler, wrap/saturate,
// terminal-count pulse and sticky overflow flag.
module updown_mod_counter #(
    parameter int WIDTH = 8,
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic             sat,
    input  logic [WIDTH-1:0] limit,
    input  logic [PRE_W-1:0] prescale,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;

    logic             pre_hit;
    logic             at_bnd;
    logic [WIDTH-1:0] load_clamp;

    assign pre_hit    = (pre_q == prescale);
    assign load_clamp = (load_val > limit) ? limit : load_val;

    // Up-boundary uses >= so a limit lowered below count still wraps.
    assign at_bnd = dir ? (count_q >= limit) : (count_q == '0);

    always_comb begin
        count_d = count_q;
        pre_d   = pre_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q & ~ovf_clr;
        if (load) begin
            count_d = load_clamp;
            pre_d   = '0;
        end else if (en) begin
            if (pre_hit) begin
                pre_d = '0;
                if (at_bnd) begin
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
                    if (!sat) begin
                        count_d = dir ? '0 : limit;
                    end
                end else if (dir) begin
                    count_d = count_q + 1'b1;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            pre_q   <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            pre_q   <= pre_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed plus randomized bench for updown_mod_counter against
// an integer reference model.
module tb_updown_mod_counter;
    localparam int W = 8;
    localparam int P = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         load;
    logic [W-1:0] load_val;
    logic         dir;
    logic         sat;
    logic [W-1:0] limit;
    logic [P-1:0] prescale;
    logic         ovf_clr;
    logic [W-1:0] count;
    logic         tc;
    logic         ovf;

    int checks = 0;
    int errors = 0;
    int m_cnt, m_pre, m_tc, m_ovf;

    updown_mod_counter #(.WIDTH(W), .PRE_W(P)) dut (
        .clk(clk), .reset(reset), .en(en), .load(load),
        .load_val(load_val), .dir(dir), .sat(sat),
        .limit(limit), .prescale(prescale), .ovf_clr(ovf_clr),
        .count(count), .tc(tc), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d",
                   tag, obs, exp);
        end
    endtask

    task automatic boundary_hit();
        m_tc  = 1;
        m_ovf = 1;
    endtask

    // Reference: what one rising edge does, from the counter rules.
    task automatic model_edge();
        int lim;
        lim = int'(limit);
        if (ovf_clr) m_ovf = 0;
        m_tc = 0;
        if (load) begin
            m_cnt = (int'(load_val) > lim) ? lim : int'(load_val);
            m_pre = 0;
        end else if (en) begin
            if (m_pre == int'(prescale)) begin
                m_pre = 0;
                if (dir) begin
                    if (m_cnt >= lim) begin
                        boundary_hit();
                        if (!sat) m_cnt = 0;
                    end else begin
                        m_cnt = m_cnt + 1;
                    end
                end else begin
                    if (m_cnt == 0) begin
                        boundary_hit();
                        if (!sat) m_cnt = lim;
                    end else begin
                        m_cnt = m_cnt - 1;
                    end
                end
            end else begin
                m_pre = (m_pre + 1) % (1 << P);
            end
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_pre = 0;
        m_tc  = 0;
        m_ovf = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("count", count, m_cnt);
        chk("tc", tc, m_tc);
        chk("ovf", ovf, m_ovf);
    endtask

    task automatic do_load(input logic [W-1:0] v);
        load     = 1'b1;
        load_val = v;
        tick();
        load     = 1'b0;
    endtask

    int exp_up[8] = '{1, 2, 3, 4, 5, 0, 1, 2};

    initial begin
        reset    = 1'b1;
        en       = 1'b0;
        load     = 1'b0;
        load_val = '0;
        dir      = 1'b1;
        sat      = 1'b0;
        limit    = 8'd5;
        prescale = '0;
        ovf_clr  = 1'b0;
        model_reset();
        #12;
        chk("rst_count", count, 0);
        chk("rst_tc", tc, 0);
        chk("rst_ovf", ovf, 0);
        @(negedge clk);
        reset = 1'b0;
        en    = 1'b1;

        for (int i = 0; i < 8; i++) begin
            tick();
            chk("wrap_seq", count, exp_up[i]);
            chk("wrap_tc", tc, (i == 5) ? 1 : 0);
        end
        chk("wrap_ovf", ovf, 1);

        do_load(8'd0);
        dir   = 1'b0;
        limit = 8'd9;
        tick();
        chk("down_wrap", count, 9);
        chk("down_tc", tc, 1);
        ovf_clr = 1'b1;
        en      = 1'b0;
        tick();
        chk("ovf_clr", ovf, 0);
        ovf_clr = 1'b0;
        en      = 1'b1;

        sat   = 1'b1;
        dir   = 1'b1;
        limit = 8'd255;
        do_load(8'd254);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sat_cnt", count, 255);
            chk("sat_tc", tc, (i > 0) ? 1 : 0);
        end
        chk("sat_ovf", ovf, 1);

        sat      = 1'b0;
        prescale = 4'd3;
        do_load(8'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("pre_cnt", count, (i == 3) ? 1 : 0);
        end
        tick();
        en = 1'b0;
        tick();
        tick();
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pre_gap", count, (i == 2) ? 2 : 1);
        end

        prescale = '0;
        limit    = 8'd100;
        do_load(8'd200);
        chk("load_clamp", count, 100);
        chk("load_tc", tc, 0);
        prescale = 4'd3;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("load_pre", count, (i == 3) ? 0 : 100);
        end

        en = 1'b0;
        do_load(8'd7);
        chk("load_dis", count, 7);
        en       = 1'b1;
        prescale = '0;

        limit = 8'd255;
        do_load(8'd50);
        limit = 8'd20;
        tick();
        chk("lim_drop", count, 0);
        chk("lim_tc", tc, 1);

        ovf_clr = 1'b1;
        limit   = 8'd0;
        tick();
        chk("clr_vs_set", ovf, 1);
        chk("lim0", count, 0);
        ovf_clr = 1'b0;

        limit = 8'd30;
        do_load(8'd12);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("areset_cnt", count, 0);
        chk("areset_tc", tc, 0);
        chk("areset_ovf", ovf, 0);
        #1 reset = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            en       = ($urandom_range(0, 7) != 0);
            load     = ($urandom_range(0, 15) == 0);
            load_val = W'($urandom);
            dir      = ($urandom_range(0, 3) != 0);
            sat      = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 31) == 0)
                limit = W'($urandom_range(0, 12));
            prescale = ($urandom_range(0, 3) == 0) ?
                       P'($urandom) : '0;
            ovf_clr  = !load && ($urandom_range(0, 19) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
